serial_mag_comp: RTL and testbench



---
 rtl/serial_mag_comp_pkg.sv | 20 ++
 rtl/serial_mag_comp_chunk_cmp.sv | 15 +
 rtl/serial_mag_comp.sv | 136 +++++++++++++
 tb/tb_serial_mag_comp.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/serial_mag_comp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encodings
// and a constant-evaluable ceiling log2 used to size counters.
package comp_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_comp_chunk_cmp.sv
// Combinational CHUNK-bit unsigned compare; equality is implied when neither
// gt nor lt is set.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_mag_comp.sv
// Multi-cycle WIDTH-bit magnitude comparator: walks CHUNK-bit slices MSB first
// and stops at the first differing slice; optional two's-complement mode.
module serial_mag_comp
  import comp_defs::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             s,
  output logic [CW-1:0]    nchunks
);

  localparam int IW = (clog2(NCHUNK) > 0) ? clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  ra_r, ra_s;
  logic [WIDTH-1:0]  rb_r, rb_s;
  logic [IW-1:0]     idx_r, idx_s;
  logic              g_r, g_s;
  logic              e_r, e_s;
  logic              s_r, s_s;
  logic [CW-1:0]     nchunks_r, nchunks_s;

  logic [CHUNK-1:0]  x_s, y_s;
  logic              gt_s, lt_s;

  assign x_s = ra_r[idx_r*CHUNK +: CHUNK];
  assign y_s = rb_r[idx_r*CHUNK +: CHUNK];

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .x  (x_s),
    .y  (y_s),
    .gt (gt_s),
    .lt (lt_s)
  );

  // Next-state and next-datapath logic for the compare sequencer.
  always_comb begin
    state_s   = state_r;
    ra_s      = ra_r;
    rb_s      = rb_r;
    idx_s     = idx_r;
    g_s       = g_r;
    e_s       = e_r;
    s_s       = s_r;
    nchunks_s = nchunks_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          ra_s      = signed_mode ? (a ^ MSB_MASK) : a;
          rb_s      = signed_mode ? (b ^ MSB_MASK) : b;
          idx_s     = IDX_TOP;
          g_s       = 1'b0;
          e_s       = 1'b0;
          s_s       = 1'b0;
          nchunks_s = {CW{1'b0}};
          state_s   = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (gt_s) begin
          g_s       = 1'b1;
          nchunks_s = CW'(NCHUNK) - CW'(idx_r);
          state_s   = ST_DONE;
        end else if (lt_s) begin
          s_s       = 1'b1;
          nchunks_s = CW'(NCHUNK) - CW'(idx_r);
          state_s   = ST_DONE;
        end else if (idx_r == {IW{1'b0}}) begin
          e_s       = 1'b1;
          nchunks_s = CW'(NCHUNK);
          state_s   = ST_DONE;
        end else begin
          idx_s   = idx_r - IW'(1);
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any compare in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ra_r      <= {WIDTH{1'b0}};
      rb_r      <= {WIDTH{1'b0}};
      idx_r     <= {IW{1'b0}};
      g_r       <= 1'b0;
      e_r       <= 1'b0;
      s_r       <= 1'b0;
      nchunks_r <= {CW{1'b0}};
    end else begin
      state_r   <= state_s;
      ra_r      <= ra_s;
      rb_r      <= rb_s;
      idx_r     <= idx_s;
      g_r       <= g_s;
      e_r       <= e_s;
      s_r       <= s_s;
      nchunks_r <= nchunks_s;
    end
  end

  assign in_ready = (state_r == ST_IDLE);
  assign busy     = (state_r == ST_RUN);
  assign done     = (state_r == ST_DONE);
  assign g        = g_r;
  assign e        = e_r;
  assign s        = s_r;
  assign nchunks  = nchunks_r;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed self-checking bench for serial_mag_comp at WIDTH=16, CHUNK=4.
module tb_serial_mag_comp;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        g;
  logic        e;
  logic        s;
  logic [2:0]  nchunks;

  int checks_r;
  int failures_r;

  serial_mag_comp #(.WIDTH(16), .CHUNK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .in_ready    (in_ready),
    .busy        (busy),
    .done        (done),
    .g           (g),
    .e           (e),
    .s           (s),
    .nchunks     (nchunks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r = checks_r + 1;
    if (got !== exp) begin
      failures_r = failures_r + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done after the accept edge; returns edges counted.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < 20) begin
      step();
      cnt = cnt + 1;
      if (done) break;
    end
  endtask

  // Issues one compare from IDLE and checks latency, flags, and result hold.
  task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic sm, input logic eg, input logic ee, input logic es,
                         input int en);
    int cnt;
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    step();
    start = 1'b0;
    a = ~av; b = av; signed_mode = ~sm;
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(cnt);
    check_eq({tag, "_lat"}, cnt, en);
    check_eq({tag, "_gesn"}, {25'd0, g, e, s, 1'b0, nchunks}, {25'd0, eg, ee, es, 1'b0, 3'(en)});
    check_eq({tag, "_rdy_in_done"}, {31'd0, in_ready}, 32'd0);
    step();
    check_eq({tag, "_after"}, {26'd0, in_ready, done, g, e, s, busy},
             {26'd0, 1'b1, 1'b0, eg, ee, es, 1'b0});
  endtask

  initial begin
    int cnt;
    int dones;
    checks_r = 0;
    failures_r = 0;
    rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000; signed_mode = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_eq("reset", {25'd0, g, e, s, done, in_ready, busy, 1'b0, nchunks},
             {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});

    run_cmp("u_gt_msb", 16'hA000, 16'h5FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run_cmp("u_eq",     16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    run_cmp("u_lt_c3",  16'h00A0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    run_cmp("u_8000",   16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run_cmp("s_8000",   16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1);

    // Signed -1 vs -2 with a competing start issued mid-RUN.
    a = 16'hFFFF; b = 16'hFFFE; signed_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    cnt = 2;
    while (cnt < 20 && !done) begin
      step();
      cnt = cnt + 1;
    end
    check_eq("s_neg_lat", cnt, 32'd4);
    check_eq("s_neg_res", {28'd0, g, e, s, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check_eq("s_neg_n", {29'd0, nchunks}, 32'd4);
    step();
    step();
    check_eq("s_neg_no_requeue", {30'd0, in_ready, busy}, {30'd0, 1'b1, 1'b0});

    // Reset on the second RUN cycle aborts with no done pulse.
    a = 16'h0000; b = 16'h0000; signed_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_state", {25'd0, g, e, s, done, in_ready, busy, 1'b0, nchunks},
             {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dones = dones + 1;
    end
    check_eq("abort_no_done", dones, 32'd0);

    run_cmp("post_abort", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
